// File: rtl/uart_rx_fifo_writer.sv
// UART 8N1 receiver feeding the 8-bit write port of a sync FIFO.
// Each frame ends in exactly one of: a write, an overflow drop (FIFO full at
// the stop sample) or a frame error (stop bit low). A frame error is followed
// by a BREAK wait so that a line held low reports only once. Hardware flow
// control (rts_n) follows the FIFO almost-full flag one cycle later.
// state_dbg exposes the FSM state for checkers (0 = IDLE).
module uart_rx_fifo_writer #(
  parameter int CLKS_PER_BIT = 434,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 wr_full,
  input  logic                 almost_full,
  input  logic                 stats_clr,
  output logic                 wr_en,
  output logic [7:0]           wr_data,
  output logic                 rts_n,
  output logic                 frame_err,
  output logic                 overflow,
  output logic [CNT_WIDTH-1:0] frame_err_cnt,
  output logic [CNT_WIDTH-1:0] ovf_cnt,
  output logic [2:0]           state_dbg
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic                  rx_meta_q, rx_meta_d;
  logic                  rx_sync_q, rx_sync_d;
  logic [CW-1:0]         clk_cnt_q, clk_cnt_d;
  logic [2:0]            bit_idx_q, bit_idx_d;
  logic [7:0]            shift_q, shift_d;
  logic                  wr_en_q, wr_en_d;
  logic [7:0]            wr_data_q, wr_data_d;
  logic                  frame_err_q, frame_err_d;
  logic                  overflow_q, overflow_d;
  logic                  rts_n_q, rts_n_d;
  logic [CNT_WIDTH-1:0]  fe_cnt_q, fe_cnt_d;
  logic [CNT_WIDTH-1:0]  ovf_cnt_q, ovf_cnt_d;
  logic                  fe_inc, ovf_inc;

  // Next-state logic: synchronizer, frame FSM, registered outputs, counters.
  always_comb begin
    rx_meta_d   = rx;
    rx_sync_d   = rx_meta_q;
    state_d     = state_q;
    clk_cnt_d   = clk_cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    wr_en_d     = 1'b0;
    wr_data_d   = wr_data_q;
    frame_err_d = 1'b0;
    overflow_d  = 1'b0;
    fe_inc      = 1'b0;
    ovf_inc     = 1'b0;
    rts_n_d     = almost_full;

    case (state_q)
      S_IDLE: begin
        clk_cnt_d = '0;
        if (!rx_sync_q) state_d = S_START;
      end
      S_START: begin
        // Re-check the line mid start bit; a high line means a glitch.
        if (clk_cnt_q == HALF_LAST) begin
          clk_cnt_d = '0;
          bit_idx_d = 3'd0;
          state_d   = rx_sync_q ? S_IDLE : S_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          shift_d   = {rx_sync_q, shift_q[7:1]};
          if (bit_idx_q == 3'd7) state_d = S_STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          if (rx_sync_q) begin
            state_d = S_IDLE;
            if (!wr_full) begin
              wr_en_d   = 1'b1;
              wr_data_d = shift_q;
            end else begin
              overflow_d = 1'b1;
              ovf_inc    = 1'b1;
            end
          end else begin
            frame_err_d = 1'b1;
            fe_inc      = 1'b1;
            state_d     = S_BREAK;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      S_BREAK: begin
        clk_cnt_d = '0;
        if (rx_sync_q) state_d = S_IDLE;
      end
      default: begin
        state_d   = S_IDLE;
        clk_cnt_d = '0;
      end
    endcase

    // Clear wins over a same-cycle increment; counters stick at all-ones.
    if (stats_clr)                     fe_cnt_d = '0;
    else if (fe_inc && fe_cnt_q != '1) fe_cnt_d = fe_cnt_q + 1'b1;
    else                               fe_cnt_d = fe_cnt_q;

    if (stats_clr)                       ovf_cnt_d = '0;
    else if (ovf_inc && ovf_cnt_q != '1) ovf_cnt_d = ovf_cnt_q + 1'b1;
    else                                 ovf_cnt_d = ovf_cnt_q;
  end

  // State register; synchronous reset aborts any frame in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      state_q     <= S_IDLE;
      clk_cnt_q   <= '0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'h00;
      wr_en_q     <= 1'b0;
      wr_data_q   <= 8'h00;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
      rts_n_q     <= 1'b0;
      fe_cnt_q    <= '0;
      ovf_cnt_q   <= '0;
    end else begin
      rx_meta_q   <= rx_meta_d;
      rx_sync_q   <= rx_sync_d;
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      wr_en_q     <= wr_en_d;
      wr_data_q   <= wr_data_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
      rts_n_q     <= rts_n_d;
      fe_cnt_q    <= fe_cnt_d;
      ovf_cnt_q   <= ovf_cnt_d;
    end
  end

  assign wr_en         = wr_en_q;
  assign wr_data       = wr_data_q;
  assign frame_err     = frame_err_q;
  assign overflow      = overflow_q;
  assign rts_n         = rts_n_q;
  assign frame_err_cnt = fe_cnt_q;
  assign ovf_cnt       = ovf_cnt_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_uart_rx_fifo_writer.sv
// Directed bench for uart_rx_fifo_writer at 16 clocks per bit.
// Inputs change on the falling edge; outputs are observed on the falling edge.
module tb_uart_rx_fifo_writer;

  localparam int CPB = 16;
  localparam int CW  = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx = 1'b1;
  logic          wr_full = 1'b0;
  logic          almost_full = 1'b0;
  logic          stats_clr = 1'b0;
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          rts_n;
  logic          frame_err;
  logic          overflow;
  logic [CW-1:0] frame_err_cnt;
  logic [CW-1:0] ovf_cnt;
  logic [2:0]    state_dbg;

  uart_rx_fifo_writer #(.CLKS_PER_BIT(CPB), .CNT_WIDTH(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx           (rx),
    .wr_full      (wr_full),
    .almost_full  (almost_full),
    .stats_clr    (stats_clr),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rts_n        (rts_n),
    .frame_err    (frame_err),
    .overflow     (overflow),
    .frame_err_cnt(frame_err_cnt),
    .ovf_cnt      (ovf_cnt),
    .state_dbg    (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  int wr_seen = 0;
  int fe_seen = 0;
  int ovf_seen = 0;
  int last_wr_cyc = -1;
  logic prev_wr = 1'b0;
  logic [7:0] last_data = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write is matched against the expected queue.
  always @(negedge clk) begin
    if (rst) begin
      prev_wr   = 1'b0;
      last_data = 8'h00;
    end else begin
      if (wr_en) begin
        wr_seen++;
        last_wr_cyc = cyc;
        check("wr_en_width", 32'(prev_wr), 32'd0);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_write: got data 0x%0h, expected no write", wr_data);
        end else begin
          check("wr_data", 32'(wr_data), 32'(exp_q.pop_front()));
        end
        last_data = wr_data;
      end else if (wr_data !== last_data) begin
        n_checks++;
        n_err++;
        $display("FAIL wr_data_hold: got 0x%0h, expected 0x%0h", wr_data, last_data);
      end
      if (frame_err) fe_seen++;
      if (overflow)  ovf_seen++;
      prev_wr = wr_en;
    end
  end

  // ---------------- driver ----------------
  // full_mode: 0 = FIFO not full, 1 = full for whole frame, 2 = full early only.
  // stop_low > 0 holds the line low for that many cycles from the stop bit start.
  task automatic send_frame(input logic [7:0] d, input int stop_low, input int full_mode,
                            input int gap, input bit clr, output int t0);
    int total;
    total = (stop_low > CPB) ? (9 * CPB + stop_low) : (10 * CPB);
    t0 = 0;
    for (int i = 0; i < total; i++) begin
      @(negedge clk);
      if (i == 0) t0 = cyc;
      if (i < CPB)            rx = 1'b0;
      else if (i < 9 * CPB)   rx = d[(i - CPB) / CPB];
      else if (stop_low > 0 && i < 9 * CPB + stop_low) rx = 1'b0;
      else                    rx = 1'b1;
      wr_full   = (full_mode == 1) || (full_mode == 2 && i < 100);
      stats_clr = clr && (i == 154);
    end
    wr_full   = 1'b0;
    stats_clr = 1'b0;
    rx        = 1'b1;
    for (int i = 0; i < gap; i++) @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_wr_en"},     32'(wr_en), 32'd0);
    check({tag, "_wr_data"},   32'(wr_data), 32'd0);
    check({tag, "_rts_n"},     32'(rts_n), 32'd0);
    check({tag, "_frame_err"}, 32'(frame_err), 32'd0);
    check({tag, "_overflow"},  32'(overflow), 32'd0);
    check({tag, "_fe_cnt"},    32'(frame_err_cnt), 32'd0);
    check({tag, "_ovf_cnt"},   32'(ovf_cnt), 32'd0);
    check({tag, "_state"},     32'(state_dbg), 32'd0);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [7:0] data;
    int stop_low;
    int full_mode;
    int gap;
    int exp_wr;
    int exp_fe;
    int exp_ovf;
    int exp_fe_cnt;
    int exp_ovf_cnt;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int t0, w0, f0, o0;

    vecs[0] = '{8'hA5, 0,  0, 20, 1, 0, 0, 0, 0};
    vecs[1] = '{8'h00, 0,  0, 0,  1, 0, 0, 0, 0};
    vecs[2] = '{8'hFF, 0,  0, 0,  1, 0, 0, 0, 0};
    vecs[3] = '{8'h55, 0,  0, 20, 1, 0, 0, 0, 0};
    vecs[4] = '{8'h3C, 40, 0, 20, 0, 1, 0, 1, 0};
    vecs[5] = '{8'h12, 0,  0, 20, 1, 0, 0, 1, 0};
    vecs[6] = '{8'h77, 0,  1, 20, 0, 0, 1, 1, 1};
    vecs[7] = '{8'h88, 0,  0, 20, 1, 0, 0, 1, 1};
    vecs[8] = '{8'hC3, 0,  2, 20, 1, 0, 0, 1, 1};

    // Reset with almost_full high: rts_n must still read its reset value.
    rst = 1'b1;
    almost_full = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    almost_full = 1'b0;
    repeat (5) @(negedge clk);

    for (int v = 0; v < 9; v++) begin
      w0 = wr_seen; f0 = fe_seen; o0 = ovf_seen;
      if (vecs[v].exp_wr != 0) exp_q.push_back(vecs[v].data);
      send_frame(vecs[v].data, vecs[v].stop_low, vecs[v].full_mode, vecs[v].gap, 1'b0, t0);
      check($sformatf("v%0d_wr_count", v),  32'(wr_seen - w0), 32'(vecs[v].exp_wr));
      check($sformatf("v%0d_fe_pulses", v), 32'(fe_seen - f0), 32'(vecs[v].exp_fe));
      check($sformatf("v%0d_ovf_pulses", v), 32'(ovf_seen - o0), 32'(vecs[v].exp_ovf));
      check($sformatf("v%0d_fe_cnt", v),    32'(frame_err_cnt), 32'(vecs[v].exp_fe_cnt));
      check($sformatf("v%0d_ovf_cnt", v),   32'(ovf_cnt), 32'(vecs[v].exp_ovf_cnt));
      // First frame: line drops before edge T = t0+1, write visible after edge T+154.
      if (v == 0) check("v0_write_latency", 32'(last_wr_cyc), 32'(t0 + 155));
    end

    // Short low glitch on the line is rejected in START.
    w0 = wr_seen; f0 = fe_seen; o0 = ovf_seen;
    @(negedge clk);
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    check("glitch_wr",    32'(wr_seen - w0), 32'd0);
    check("glitch_flags", 32'((fe_seen - f0) + (ovf_seen - o0)), 32'd0);
    check("glitch_state", 32'(state_dbg), 32'd0);

    // Flow control follows almost_full one cycle later.
    almost_full = 1'b1;
    check("rts_n_before_edge", 32'(rts_n), 32'd0);
    @(negedge clk);
    check("rts_n_asserted", 32'(rts_n), 32'd1);
    almost_full = 1'b0;
    @(negedge clk);
    check("rts_n_released", 32'(rts_n), 32'd0);

    // 300 more overflows: counter sticks at 255.
    o0 = ovf_seen;
    for (int k = 0; k < 300; k++) send_frame(8'h5A, 0, 1, 0, 1'b0, t0);
    repeat (10) @(negedge clk);
    check("sat_ovf_pulses", 32'(ovf_seen - o0), 32'd300);
    check("sat_ovf_cnt",    32'(ovf_cnt), 32'd255);

    // Clear in the same cycle as an overflow increment: clear wins.
    o0 = ovf_seen;
    send_frame(8'h5A, 0, 1, 10, 1'b1, t0);
    check("clr_ovf_pulse", 32'(ovf_seen - o0), 32'd1);
    check("clr_ovf_cnt",   32'(ovf_cnt), 32'd0);
    check("clr_fe_cnt",    32'(frame_err_cnt), 32'd0);

    // Counting resumes after a clear; leaves a nonzero counter for the reset test.
    send_frame(8'h5A, 0, 1, 10, 1'b0, t0);
    check("post_clr_ovf_cnt", 32'(ovf_cnt), 32'd1);

    // Reset in the middle of DATA: no write, no flag, all outputs at reset values.
    w0 = wr_seen; f0 = fe_seen; o0 = ovf_seen;
    almost_full = 1'b1;
    @(negedge clk);
    rx = 1'b0;
    repeat (46) @(negedge clk);
    check("mid_data_state", 32'(state_dbg), 32'd2);
    rst = 1'b1;
    rx  = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_values("midreset");
    rst = 1'b0;
    almost_full = 1'b0;
    repeat (200) @(negedge clk);
    check("midreset_no_write", 32'(wr_seen - w0), 32'd0);
    check("midreset_no_flags", 32'((fe_seen - f0) + (ovf_seen - o0)), 32'd0);
    check("midreset_idle",     32'(state_dbg), 32'd0);

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
